// File: rtl/lut_if.sv
// Lookup bus between a CORDIC core and its arctangent table.
// Carries the iteration index, read strobe and the table result with its flags.
// The master drives index/rd_en; the slave (the table) drives the result side.
interface lut_if;
  logic [4:0]  index;
  logic        rd_en;
  logic [17:0] return_angle;
  logic        last;
  logic        beyond;
  logic        valid;

  modport master (
    output index,
    output rd_en,
    input  return_angle,
    input  last,
    input  beyond,
    input  valid
  );

  modport slave (
    input  index,
    input  rd_en,
    output return_angle,
    output last,
    output beyond,
    output valid
  );
endinterface

// File: rtl/lut.sv
// CORDIC arctangent ROM: atan(2^-i) in signed Q2.16, plus last/beyond flags.
// Latency 0 (combinational, valid tied high); 1 cycle when LUT_REG_OUT_EN is defined.
// No backpressure; registered build launches one lookup per cycle with rd_en, holds data otherwise.
module lut (
  input  logic  clock,
  input  logic  reset,
  lut_if.slave  bus
);

  // round(atan(2^-i) * 65536), half-up; entries past 16 round below one LSB and read 0
  function automatic logic [17:0] atan_rom(input logic [4:0] i);
    logic [17:0] v;
    case (i)
      5'd0:    v = 18'd51472;
      5'd1:    v = 18'd30386;
      5'd2:    v = 18'd16055;
      5'd3:    v = 18'd8150;
      5'd4:    v = 18'd4091;
      5'd5:    v = 18'd2047;
      5'd6:    v = 18'd1024;
      5'd7:    v = 18'd512;
      5'd8:    v = 18'd256;
      5'd9:    v = 18'd128;
      5'd10:   v = 18'd64;
      5'd11:   v = 18'd32;
      5'd12:   v = 18'd16;
      5'd13:   v = 18'd8;
      5'd14:   v = 18'd4;
      5'd15:   v = 18'd2;
      5'd16:   v = 18'd1;
      default: v = 18'd0;
    endcase
    return v;
  endfunction

  logic [17:0] angle_c;
  logic        last_c;
  logic        beyond_c;

  // Table lookup and flags for the index currently presented
  always_comb begin
    angle_c  = atan_rom(bus.index);
    last_c   = (angle_c == 18'd1);
    beyond_c = (bus.index > 5'd16);
  end

`ifdef LUT_REG_OUT_EN
  logic [17:0] angle_q;
  logic        last_q;
  logic        beyond_q;
  logic        valid_q;

  // Output register: reset clears everything, rd_en captures, idle drops valid and holds data
  always_ff @(posedge clock) begin
    if (reset) begin
      angle_q  <= 18'd0;
      last_q   <= 1'b0;
      beyond_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (bus.rd_en) begin
      angle_q  <= angle_c;
      last_q   <= last_c;
      beyond_q <= beyond_c;
      valid_q  <= 1'b1;
    end else begin
      valid_q  <= 1'b0;
    end
  end

  assign bus.return_angle = angle_q;
  assign bus.last         = last_q;
  assign bus.beyond       = beyond_q;
  assign bus.valid        = valid_q;
`else
  // Combinational build: clock, reset and rd_en play no part in the result
  wire unused_inputs = &{1'b0, clock, reset, bus.rd_en};

  assign bus.return_angle = angle_c;
  assign bus.last         = last_c;
  assign bus.beyond       = beyond_c;
  assign bus.valid        = 1'b1;
`endif

endmodule

// File: tb/tb_lut.sv
// Bench for the CORDIC arctangent ROM, covering whichever build LUT_REG_OUT_EN selects.
// Expected angles come from real-valued atan with half-up rounding.
// Reports each miscompare and a one-line summary.
module tb_lut;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  lut_if bus ();

  lut dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: atan(2^-i) scaled by 2^16, round half-up; table stops at 16
  function automatic int ref_angle(input int i);
    real x;
    x = 1.0;
    for (int k = 0; k < i; k++) x = x / 2.0;
    if (i > 16) return 0;
    return int'($floor($atan(x) * 65536.0 + 0.5));
  endfunction

`ifdef LUT_REG_OUT_EN
  int m_angle, m_last, m_beyond, m_valid;

  // One clock: drive at negedge, model the edge, compare just after the posedge
  task automatic step(input logic rst, input logic rd, input int idx, input string tag);
    @(negedge clock);
    reset     = rst;
    bus.rd_en = rd;
    bus.index = 5'(idx);
    @(posedge clock);
    if (rst) begin
      m_angle = 0; m_last = 0; m_beyond = 0; m_valid = 0;
    end else if (rd) begin
      m_angle  = ref_angle(idx);
      m_last   = (m_angle == 1) ? 1 : 0;
      m_beyond = (idx > 16) ? 1 : 0;
      m_valid  = 1;
    end else begin
      m_valid = 0;
    end
    #1;
    check({tag, ".angle"},  32'(bus.return_angle), 32'(m_angle));
    check({tag, ".last"},   32'(bus.last),         32'(m_last));
    check({tag, ".beyond"}, 32'(bus.beyond),       32'(m_beyond));
    check({tag, ".valid"},  32'(bus.valid),        32'(m_valid));
  endtask

  initial begin
    bus.index = 5'd0;
    bus.rd_en = 1'b0;
    // Reset for two cycles clears the outputs
    step(1'b1, 1'b1, 5, "rst0");
    step(1'b1, 1'b0, 5, "rst1");
    // First read after reset
    step(1'b0, 1'b1, 0, "first");
    check("first.const", 32'(bus.return_angle), 32'd51472);
    // Back-to-back stream 0..16, last only after index 16
    for (int i = 0; i <= 16; i++) step(1'b0, 1'b1, i, "stream");
    check("stream.last16", 32'(bus.last), 32'd1);
    // Reset beats rd_en on the same edge
    step(1'b0, 1'b1, 2, "pre_rst");
    step(1'b1, 1'b1, 3, "rst_rd");
    check("rst_rd.const", 32'(bus.return_angle), 32'd0);
    // Read index 3 then idle: valid drops, data holds
    step(1'b0, 1'b1, 3, "rd3");
    step(1'b0, 1'b0, 9, "hold");
    check("hold.const", 32'(bus.return_angle), 32'd8150);
    // Random mix of reads, idles and resets
    for (int n = 0; n < 200; n++)
      step(($urandom_range(15) == 0), ($urandom_range(3) != 0), $urandom_range(31), "rand");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
`else
  // Apply an index combinationally and compare all outputs
  task automatic probe(input int idx, input string tag);
    int a;
    bus.index = 5'(idx);
    bus.rd_en = 1'($urandom_range(1));
    #1;
    a = ref_angle(idx);
    check({tag, ".angle"},  32'(bus.return_angle), 32'(a));
    check({tag, ".last"},   32'(bus.last),         (a == 1) ? 32'd1 : 32'd0);
    check({tag, ".beyond"}, 32'(bus.beyond),       (idx > 16) ? 32'd1 : 32'd0);
    check({tag, ".valid"},  32'(bus.valid),        32'd1);
  endtask

  initial begin
    bus.index = 5'd0;
    bus.rd_en = 1'b0;
    // Reset held high has no effect on the combinational result
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    probe(0, "in_reset");
    check("in_reset.const", 32'(bus.return_angle), 32'd51472);
    reset = 1'b0;
    // Full sweep, with a few spot values fixed by hand
    for (int i = 0; i < 32; i++) probe(i, "sweep");
    probe(5, "idx5");
    check("idx5.const", 32'(bus.return_angle), 32'd2047);
    probe(16, "idx16");
    check("idx16.last", 32'(bus.last), 32'd1);
    probe(17, "idx17");
    check("idx17.beyond", 32'(bus.beyond), 32'd1);
    // Random indices with reset and rd_en toggling underneath
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      reset = 1'($urandom_range(1));
      probe($urandom_range(31), "rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
`endif

endmodule
